spin_pulse_sequencer: RTL
=========================

Name: spin_pulse_sequencer

Overview:
- Upstream feeder for the output scaler: stores a programmable sequence of spin amplitudes and replays it as one `val_out` / `val_out_valid` beat per programmed period.
- Each beat becomes one DAC pulse downstream.
- Configured and started over the shared 32-bit GPIO bus; runs a fixed number of repetitions or until stopped.

Parameters:
- `DEPTH`, 256, sequence memory entries (power of two); `AW = clog2(DEPTH)`.
- `ctrl_addr`, 8'h10, GPIO register: bit0 start, bit1 stop.
- `len_addr`, 8'h11, sequence length, 0..DEPTH.
- `period_addr`, 8'h12, cycles between beats; 0 is treated as 1.
- `rep_addr`, 8'h13, repetition count; 0 means infinite.
- `waddr_addr`, 8'h14, memory write pointer.
- `wdata_addr`, 8'h15, memory write data; pointer auto-increments.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `gpio_in`  in  32  [15:0] payload, [23:16] register address, [24] w_clk strobe
- `val_out`  out  `num_bits`  spin amplitude to the output scaler
- `val_out_valid`  out  1  beat strobe
- `busy`  out  1  sequence running
- `done`  out  1  one-cycle pulse on natural completion

Behaviour:
- Clock and reset:
  - Single clock; reset is asynchronous, active-low (`rst`).
  - All outputs and registers clear to 0 on reset; state goes to IDLE.
- GPIO write strobe:
  - `gpio_in` is synchronous to `clk`; `gpio_in[24]` is registered once.
  - A write occurs on the edge where the current sample is 1 and the previous sample is 0.
  - A held-high strobe writes exactly once.
- Register writes:
  - len/period/rep/waddr: payload low bits.
  - wdata: `mem[waddr] <= payload[num_bits-1:0]`, then `waddr <= waddr+1`, wrapping at DEPTH-1 to 0.
  - Memory writes are allowed in any state; a write during RUN to an address not yet played takes effect.
- Shadowing: len, period and rep are copied to shadow registers at start. Writes during RUN affect only the next run.
- Start:
  - ctrl write with bit0=1 in IDLE and len≠0 starts a run.
  - Start with len=0, or start while not IDLE, is ignored.
  - bit0 and bit1 both set: stop wins.
- States:
  - IDLE → LOAD → EMIT → WAIT ↔ EMIT → IDLE.
  - LOAD (1 cycle): latch shadows, set idx=0, rep_cnt=0, issue memory read of `mem[0]`. `busy` is 1 from LOAD onward.
  - EMIT (1 cycle): `val_out_valid=1`, `val_out` = registered read data of `mem[idx]`.
    - Advance idx; on idx=len-1, wrap idx to 0 and increment rep_cnt.
    - Prefetch the next entry.
  - WAIT: P-1 cycles, where P = max(period,1). P=1 skips WAIT, giving back-to-back beats.
- Latency and spacing:
  - The first valid is high in the 2nd cycle after the edge that sampled the start strobe (LOAD, then EMIT).
  - Beat k is at T0 + k·P.
- Completion:
  - Completes after the EMIT of idx=len-1 when rep≠0 and rep_cnt+1=rep.
  - Next cycle: `done=1` for one cycle, `busy=0`, state IDLE.
  - rep=0: repeats forever.
- Stop:
  - ctrl bit1 in any non-IDLE state forces IDLE on the next edge.
  - `val_out_valid` and `busy` are 0 from that edge; `done` is not pulsed.
  - A beat coincident with the stop-strobe edge is still emitted.
- `val_out` holds its last value when not valid. The downstream stage ignores it without valid.
- Reset mid-run: immediate abort. Memory contents need not survive reset.
- Widths:
  - len uses AW+1 bits so len=DEPTH is legal.
  - period is 16 bits; rep is 16 bits.
  - Values wider than a field are truncated.

Decomposition:
- `ising_config` supplies `num_bits`.
- Add to `ising_config`: GPIO field constants `GPIO_WCLK_BIT=24`, `GPIO_ADDR_LSB=16`, `GPIO_DATA_MSB=15`.
- Add to `ising_config`: typedef `seq_state_t` {IDLE, LOAD, EMIT, WAIT}.
- One sub-module: `gpio_reg_decoder`, which does strobe edge detection and address match, and outputs a one-cycle `wr_en` plus register select and payload. It is reusable by other GPIO-programmed blocks.
- Memory is an inferred simple dual-port RAM with registered read, inside the top module.

Test Plan:
- Load mem[0..3]=5,9,13,17; len=4, period=3, rep=2; start.
  → Valid at T0, T0+3, …, T0+21 with values 5,9,13,17,5,9,13,17.
  → `done` at T0+22; `busy` low at T0+22.
- period=0, len=3, rep=1.
  → Three consecutive valid cycles, then a `done` pulse the next cycle.
- rep=0, len=2, period=4; let 10 beats pass; write stop.
  → Valid ceases from the stop edge, `done` never asserts, `busy`=0.
- Start with len=0; start again while busy.
  → No valid, `busy` stays 0; the second start does not restart idx (beat order unchanged).
- Hold `gpio_in[24]` high 5 cycles on a wdata write.
  → Only one memory entry written; waddr advances by 1.
  → Write at waddr=DEPTH-1 wraps waddr to 0.
- Assert `rst` mid-WAIT.
  → All outputs 0 immediately (asynchronously); after release, state is IDLE and a new start runs normally.

Source files
------------

// File: rtl/ising_config.sv
// ising_config: shared configuration for the Ising pulse datapath.
//   num_bits        - spin amplitude width delivered to the output scaler
//   GPIO_*          - field positions inside the 32-bit GPIO bus word
//   *_addr          - GPIO register map of the spin pulse sequencer
//   seq_state_t     - sequencer FSM states
//   reg_sel_t       - register select offsets relative to ctrl_addr
package ising_config;

   localparam int unsigned num_bits = 16;

   localparam int unsigned GPIO_WCLK_BIT = 24;
   localparam int unsigned GPIO_ADDR_LSB = 16;
   localparam int unsigned GPIO_DATA_MSB = 15;

   localparam logic [7:0] ctrl_addr   = 8'h10;
   localparam logic [7:0] len_addr    = 8'h11;
   localparam logic [7:0] period_addr = 8'h12;
   localparam logic [7:0] rep_addr    = 8'h13;
   localparam logic [7:0] waddr_addr  = 8'h14;
   localparam logic [7:0] wdata_addr  = 8'h15;
   localparam int unsigned num_regs   = 6;

   typedef enum logic [1:0] {IDLE, LOAD, EMIT, WAIT} seq_state_t;

   // Offsets from ctrl_addr; must track the address map above.
   typedef enum logic [2:0] {
      SEL_CTRL, SEL_LEN, SEL_PERIOD, SEL_REP, SEL_WADDR, SEL_WDATA
   } reg_sel_t;

endpackage

// File: rtl/spin_pulse_sequencer_if.sv
// spin_pulse_sequencer_if: GPIO bus input and beat output of the sequencer.
//   gpio_in       - [15:0] payload, [23:16] address, [24] write strobe
//   val_out       - spin amplitude to the output scaler
//   val_out_valid - beat strobe
//   busy          - sequence running
//   done          - one-cycle pulse on natural completion
// master: bus owner / beat consumer; slave: the sequencer.
interface spin_pulse_sequencer_if;
   logic [31:0]                       gpio_in;
   logic [ising_config::num_bits-1:0] val_out;
   logic                              val_out_valid;
   logic                              busy;
   logic                              done;

   modport master (output gpio_in, input val_out, val_out_valid, busy, done);
   modport slave  (input gpio_in, output val_out, val_out_valid, busy, done);
endinterface

// File: rtl/gpio_reg_decoder.sv
// gpio_reg_decoder: turns the GPIO write strobe into a one-cycle register write.
//   clk, rst - clock, asynchronous active-low reset
//   gpio_in  - GPIO bus word
//   wr_en    - one-cycle write enable on a 0->1 strobe to an address in the window
//   wr_sel   - register offset from base_addr
//   wr_data  - payload bits
// The strobe is registered once; a held-high strobe writes exactly once.
module gpio_reg_decoder
   import ising_config::*;
#(
   parameter logic [7:0]  base_addr = 8'h10,
   parameter int unsigned n_regs    = 6,
   parameter int unsigned sel_w     = (n_regs > 1) ? $clog2(n_regs) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            gpio_in,
   output logic                   wr_en,
   output logic [sel_w-1:0]       wr_sel,
   output logic [GPIO_DATA_MSB:0] wr_data
);

   logic       strb_q;
   logic [7:0] addr;
   logic [7:0] offset;
   logic       unused_bits;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) strb_q <= 1'b0;
      else      strb_q <= gpio_in[GPIO_WCLK_BIT];
   end

   always_comb begin
      addr    = gpio_in[GPIO_ADDR_LSB +: 8];
      offset  = addr - base_addr;
      wr_sel  = offset[sel_w-1:0];
      wr_data = gpio_in[GPIO_DATA_MSB:0];
      // Unsigned wrap of offset makes addresses below base_addr fall outside too.
      wr_en   = gpio_in[GPIO_WCLK_BIT] & ~strb_q & (offset < 8'(n_regs));
   end

   assign unused_bits = ^gpio_in[31:25];

endmodule

// File: rtl/spin_pulse_sequencer.sv
// spin_pulse_sequencer: replays a programmed amplitude sequence, one beat per period.
//   clk, rst - clock, asynchronous active-low reset
//   bus      - spin_pulse_sequencer_if.slave (gpio_in in; val_out, val_out_valid,
//              busy, done out)
// Memory is a simple dual-port RAM with registered read; the read port prefetches
// the next entry so beats can run back to back when the period is 1.
module spin_pulse_sequencer
   import ising_config::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   spin_pulse_sequencer_if.slave  bus
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned SelW = $clog2(num_regs);

   logic                   wr_en;
   logic [SelW-1:0]        wr_sel;
   logic [GPIO_DATA_MSB:0] wr_data;

   gpio_reg_decoder #(
      .base_addr (ctrl_addr),
      .n_regs    (num_regs),
      .sel_w     (SelW)
   ) u_dec (
      .clk     (clk),
      .rst     (rst),
      .gpio_in (bus.gpio_in),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_data (wr_data)
   );

   // Programmed registers and run-time shadows.
   logic [AW:0]          len_q, len_s_q;
   logic [15:0]          period_q, per_s_q;
   logic [15:0]          rep_q, rep_s_q;
   logic [15:0]          rep_cnt_q, wait_cnt_q;
   logic [AW-1:0]        waddr_q, idx_q;
   seq_state_t           state_q;
   logic                 valid_q, busy_q, done_q;
   logic [num_bits-1:0]  hold_q, rd_data_q;
   logic [num_bits-1:0]  mem [DEPTH];

   logic          ctrl_wr, start_req, stop_req, mem_wr;
   logic          last, rep_done;
   logic [AW-1:0] idx_nxt, rd_addr;
   logic [15:0]   per_eff;

   always_comb begin
      ctrl_wr   = wr_en & (wr_sel == SEL_CTRL);
      stop_req  = ctrl_wr & wr_data[1];
      start_req = ctrl_wr & wr_data[0] & ~wr_data[1];
      mem_wr    = wr_en & (wr_sel == SEL_WDATA);
      last      = ({1'b0, idx_q} == (len_s_q - 1'b1));
      idx_nxt   = last ? '0 : idx_q + 1'b1;
      per_eff   = (per_s_q == '0) ? 16'd1 : per_s_q;
      rep_done  = (rep_s_q != '0) && ((rep_cnt_q + 16'd1) == rep_s_q);
      // EMIT reads ahead so the next beat's data is ready on the following cycle.
      rd_addr   = idx_q;
      if (state_q == LOAD)      rd_addr = '0;
      else if (state_q == EMIT) rd_addr = idx_nxt;
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem[waddr_q] <= wr_data[num_bits-1:0];
      rd_data_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q      <= '0;
         period_q   <= '0;
         rep_q      <= '0;
         waddr_q    <= '0;
         len_s_q    <= '0;
         per_s_q    <= '0;
         rep_s_q    <= '0;
         rep_cnt_q  <= '0;
         wait_cnt_q <= '0;
         idx_q      <= '0;
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hold_q     <= '0;
      end else begin
         if (wr_en) begin
            case (wr_sel)
               SEL_LEN:    len_q    <= wr_data[AW:0];
               SEL_PERIOD: period_q <= wr_data;
               SEL_REP:    rep_q    <= wr_data;
               SEL_WADDR:  waddr_q  <= wr_data[AW-1:0];
               SEL_WDATA:  waddr_q  <= waddr_q + 1'b1;
               default:    ;
            endcase
         end

         if (valid_q) hold_q <= rd_data_q;
         done_q <= 1'b0;

         if (stop_req && (state_q != IDLE)) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_req && (len_q != '0)) begin
                     state_q   <= LOAD;
                     busy_q    <= 1'b1;
                     len_s_q   <= len_q;
                     per_s_q   <= period_q;
                     rep_s_q   <= rep_q;
                     idx_q     <= '0;
                     rep_cnt_q <= '0;
                  end
               end
               LOAD: begin
                  state_q <= EMIT;
                  valid_q <= 1'b1;
               end
               EMIT: begin
                  idx_q <= idx_nxt;
                  if (last) rep_cnt_q <= rep_cnt_q + 16'd1;
                  if (last && rep_done) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else if (per_eff == 16'd1) begin
                     state_q <= EMIT;
                     valid_q <= 1'b1;
                  end else begin
                     state_q    <= WAIT;
                     valid_q    <= 1'b0;
                     wait_cnt_q <= per_eff - 16'd1;
                  end
               end
               WAIT: begin
                  if (wait_cnt_q == 16'd1) begin
                     state_q <= EMIT;
                     valid_q <= 1'b1;
                  end else begin
                     wait_cnt_q <= wait_cnt_q - 16'd1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Outside a beat the last emitted amplitude is held.
   assign bus.val_out       = valid_q ? rd_data_q : hold_q;
   assign bus.val_out_valid = valid_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;

endmodule
